alu_md: RTL and testbench

- Parametrised successor of the pipeline ALU. It keeps a zero-latency combinational integer path and adds a multi-cycle multiply/divide unit with architectural HI/LO registers.
- It sits in the EX stage.
- The `busy` output drives the hazard unit's stall of md-dependent instructions.

---
 rtl/alu_md_pkg.sv | 35 +++
 rtl/alu_md_md_unit.sv | 136 +++++++++++++
 rtl/alu_md.sv | 73 +++++++
 tb/tb_alu_md.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_md_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_md_pkg                                                   |
// | Description : Shared operation codes for the EX-stage ALU and md unit.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package alu_md_pkg;

    typedef logic [3:0] alu_op_t;
    typedef logic [2:0] md_op_t;

    localparam alu_op_t ALU_ADDU = 4'd0;
    localparam alu_op_t ALU_SUBU = 4'd1;
    localparam alu_op_t ALU_AND  = 4'd2;
    localparam alu_op_t ALU_OR   = 4'd3;
    localparam alu_op_t ALU_XOR  = 4'd4;
    localparam alu_op_t ALU_NOR  = 4'd5;
    localparam alu_op_t ALU_LUI  = 4'd6;
    localparam alu_op_t ALU_SLT  = 4'd7;
    localparam alu_op_t ALU_SLTU = 4'd8;
    localparam alu_op_t ALU_SLLV = 4'd9;
    localparam alu_op_t ALU_SRLV = 4'd10;
    localparam alu_op_t ALU_SRAV = 4'd11;
    localparam alu_op_t ALU_EQ   = 4'd12;
    localparam alu_op_t ALU_NE   = 4'd13;

    localparam md_op_t MD_MULT  = 3'd0;
    localparam md_op_t MD_MULTU = 3'd1;
    localparam md_op_t MD_DIV   = 3'd2;
    localparam md_op_t MD_DIVU  = 3'd3;
    localparam md_op_t MD_MTHI  = 3'd4;
    localparam md_op_t MD_MTLO  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/alu_md_md_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : md_unit                                                      |
// | Description : Multi-cycle multiply/divide unit with HI/LO registers.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module md_unit
    import alu_md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_md_op,
    input  logic             i_md_start,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int c_MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW     = $clog2(c_MAXC + 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MUL  = 2'd1;
    localparam logic [1:0] c_ST_DIV  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic                      w_is_mul;
    logic                      w_is_div;
    logic signed [2*WIDTH-1:0] w_prod_s;
    logic        [2*WIDTH-1:0] w_prod_u;
    logic        [2*WIDTH-1:0] w_prod;
    logic                      w_num_neg;
    logic                      w_den_neg;
    logic        [WIDTH-1:0]   w_num_abs;
    logic        [WIDTH-1:0]   w_den_abs;
    logic        [WIDTH-1:0]   w_den_safe;
    logic        [WIDTH-1:0]   w_q_abs;
    logic        [WIDTH-1:0]   w_r_abs;
    logic        [WIDTH-1:0]   w_quo;
    logic        [WIDTH-1:0]   w_rem;

    assign w_is_mul = (i_md_op == MD_MULT) || (i_md_op == MD_MULTU);
    assign w_is_div = (i_md_op == MD_DIV)  || (i_md_op == MD_DIVU);

    assign w_prod_s = $signed(r_a) * $signed(r_b);
    assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
    assign w_prod   = (r_op == MD_MULT) ? w_prod_s : w_prod_u;

    // Signed divide via magnitudes; MIN/-1 falls out as quotient MIN, remainder 0.
    assign w_num_neg  = (r_op == MD_DIV) && r_a[WIDTH-1];
    assign w_den_neg  = (r_op == MD_DIV) && r_b[WIDTH-1];
    assign w_num_abs  = w_num_neg ? -r_a : r_a;
    assign w_den_abs  = w_den_neg ? -r_b : r_b;
    assign w_den_safe = (r_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : w_den_abs;
    assign w_q_abs    = w_num_abs / w_den_safe;
    assign w_r_abs    = w_num_abs % w_den_safe;
    assign w_quo      = (w_num_neg ^ w_den_neg) ? -w_q_abs : w_q_abs;
    assign w_rem      = w_num_neg ? -w_r_abs : w_r_abs;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= c_ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (i_md_start && w_is_mul)      w_next = c_ST_MUL;
                else if (i_md_start && w_is_div) w_next = c_ST_DIV;
            end
            c_ST_MUL, c_ST_DIV: begin
                if (r_count == CW'(1)) w_next = c_ST_IDLE;
            end
            default: w_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state != c_ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (r_state == c_ST_IDLE) begin
            if (i_md_start) begin
                if (w_is_mul || w_is_div) begin
                    r_a     <= i_a;
                    r_b     <= i_b;
                    r_op    <= i_md_op;
                    r_count <= w_is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                end else if (i_md_op == MD_MTHI) begin
                    r_hi <= i_a;
                end else if (i_md_op == MD_MTLO) begin
                    r_lo <= i_a;
                end
            end
        end else begin
            r_count <= r_count - CW'(1);
            if (r_count == CW'(1)) begin
                if (r_state == c_ST_MUL) begin
                    r_hi <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod[WIDTH-1:0];
                end else if (r_b != '0) begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end
            end
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule
`default_nettype wire

// File: rtl/alu_md.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_md                                                       |
// | Description : EX-stage combinational ALU plus multi-cycle mult/div unit.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_md
    import alu_md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_alu_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_judge,
    input  logic [2:0]       i_md_op,
    input  logic             i_md_start,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int SW = $clog2(WIDTH);

    logic [SW-1:0] w_shamt;

    assign w_shamt = i_a[SW-1:0];

    always_comb begin
        o_result = '0;
        o_judge  = 1'b0;
        case (i_alu_op)
            ALU_ADDU: o_result = i_a + i_b;
            ALU_SUBU: o_result = i_a - i_b;
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_NOR:  o_result = ~(i_a | i_b);
            ALU_LUI:  o_result = i_b << (WIDTH / 2);
            ALU_SLT:  o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_SLTU: o_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
            ALU_SLLV: o_result = i_b << w_shamt;
            ALU_SRLV: o_result = i_b >> w_shamt;
            ALU_SRAV: o_result = $signed(i_b) >>> w_shamt;
            ALU_EQ:   o_judge  = (i_a == i_b);
            ALU_NE:   o_judge  = (i_a != i_b);
            default:  o_result = '0;
        endcase
    end

    md_unit #(
        .WIDTH       (WIDTH),
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_unit (
        .clk        (clk),
        .reset      (reset),
        .i_a        (i_a),
        .i_b        (i_b),
        .i_md_op    (i_md_op),
        .i_md_start (i_md_start),
        .o_busy     (o_busy),
        .o_hi       (o_hi),
        .o_lo       (o_lo)
    );

endmodule
`default_nettype wire

// File: tb/tb_alu_md.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_md                                                    |
// | Description : Directed self-checking bench for alu_md (32- and 16-bit).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_md;
    import alu_md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a, b, result, hi, lo;
    logic [3:0]  alu_op;
    logic [2:0]  md_op;
    logic        md_start, judge, busy;

    logic [15:0] a16, b16, result16, hi16, lo16;
    logic [3:0]  alu_op16;
    logic [2:0]  md_op16;
    logic        md_start16, judge16, busy16;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    always #5 clk = ~clk;

    alu_md #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut32 (
        .clk(clk), .reset(reset), .i_a(a), .i_b(b), .i_alu_op(alu_op),
        .o_result(result), .o_judge(judge), .i_md_op(md_op), .i_md_start(md_start),
        .o_busy(busy), .o_hi(hi), .o_lo(lo)
    );

    alu_md #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) u_dut16 (
        .clk(clk), .reset(reset), .i_a(a16), .i_b(b16), .i_alu_op(alu_op16),
        .o_result(result16), .o_judge(judge16), .i_md_op(md_op16), .i_md_start(md_start16),
        .o_busy(busy16), .o_hi(hi16), .o_lo(lo16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        alu_op = op; a = x; b = y;
        #1;
    endtask

    // Issue one md op on the 32-bit unit; returns with start dropped, 1 time unit after the edge.
    task automatic issue32(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        md_op = op; a = x; b = y; md_start = 1'b1;
        step();
        md_start = 1'b0;
    endtask

    task automatic wait_idle32(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic issue16(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
        md_op16 = op; a16 = x; b16 = y; md_start16 = 1'b1;
        step();
        md_start16 = 1'b0;
    endtask

    task automatic wait_idle16(output int n);
        n = 0;
        while (busy16 && n < 100) begin
            n++;
            step();
        end
    endtask

    initial begin
        reset = 1'b0;
        a = '0; b = '0; alu_op = ALU_ADDU; md_op = 3'd6; md_start = 1'b0;
        a16 = '0; b16 = '0; alu_op16 = ALU_ADDU; md_op16 = 3'd6; md_start16 = 1'b0;
        step();
        step();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        reset = 1'b1;
        step();

        alu(ALU_ADDU, 32'hFFFF_FFFF, 32'd1);        chk("addu_wrap", {32'd0, result}, 64'd0);
        alu(ALU_SUBU, 32'd3, 32'd5);                chk("subu", {32'd0, result}, 64'hFFFF_FFFE);
        alu(ALU_SLT,  32'hFFFF_FFFF, 32'd1);        chk("slt", {32'd0, result}, 64'd1);
        alu(ALU_SLTU, 32'hFFFF_FFFF, 32'd1);        chk("sltu", {32'd0, result}, 64'd0);
        alu(ALU_SRAV, 32'd4, 32'h8000_0000);        chk("srav", {32'd0, result}, 64'hF800_0000);
        alu(ALU_SRLV, 32'd36, 32'h8000_0000);       chk("srlv_mask", {32'd0, result}, 64'h0800_0000);
        alu(ALU_SLLV, 32'd33, 32'd1);               chk("sllv_mask", {32'd0, result}, 64'd2);
        alu(ALU_LUI,  32'd0, 32'h1234);             chk("lui", {32'd0, result}, 64'h1234_0000);
        alu(ALU_NOR,  32'h0F0F_0000, 32'h0000_00F0); chk("nor", {32'd0, result}, 64'hF0F0_FF0F);
        alu(ALU_XOR,  32'hFF00_FF00, 32'h0FF0_0FF0); chk("xor", {32'd0, result}, 64'hF0F0_F0F0);
        alu(ALU_EQ,   32'd5, 32'd5);
        chk("eq_judge", {63'd0, judge}, 64'd1);
        chk("eq_result", {32'd0, result}, 64'd0);
        alu(ALU_NE,   32'd5, 32'd5);                chk("ne_judge", {63'd0, judge}, 64'd0);
        alu(4'd15,    32'd5, 32'd7);
        chk("bad_result", {32'd0, result}, 64'd0);
        chk("bad_judge", {63'd0, judge}, 64'd0);

        issue32(MD_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_idle32(cyc);
        chk("mult_cycles", 64'(cyc), 64'd5);
        chk("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        chk("mult_lo", {32'd0, lo}, 64'hFFFF_FFEB);

        issue32(MD_MULTU, 32'hFFFF_FFFD, 32'd7);
        wait_idle32(cyc);
        chk("multu_cycles", 64'(cyc), 64'd5);
        chk("multu_hi", {32'd0, hi}, 64'd6);
        chk("multu_lo", {32'd0, lo}, 64'hFFFF_FFEB);

        issue32(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        a = 32'd100; b = 32'd3;
        wait_idle32(cyc);
        chk("div_cycles", 64'(cyc), 64'd10);
        chk("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        chk("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);

        issue32(MD_MTHI, 32'h11, 32'd0);
        chk("mthi", {32'd0, hi}, 64'h11);
        chk("mthi_busy", {63'd0, busy}, 64'd0);
        issue32(MD_MTLO, 32'h22, 32'd0);
        chk("mtlo", {32'd0, lo}, 64'h22);
        issue32(MD_DIVU, 32'd7, 32'd0);
        wait_idle32(cyc);
        chk("div0_cycles", 64'(cyc), 64'd10);
        chk("div0_hi", {32'd0, hi}, 64'h11);
        chk("div0_lo", {32'd0, lo}, 64'h22);

        // Overflow divide with an MTLO and operand churn while busy.
        issue32(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        step();
        md_op = MD_MTLO; a = 32'h55; md_start = 1'b1;
        step();
        md_start = 1'b0; a = 32'd1; b = 32'd1;
        chk("ovf_mtlo_ignored", {32'd0, lo}, 64'h22);
        cyc = 2;
        while (busy && cyc < 100) begin
            cyc++;
            step();
        end
        chk("ovf_cycles", 64'(cyc), 64'd10);
        chk("ovf_lo", {32'd0, lo}, 64'h8000_0000);
        chk("ovf_hi", {32'd0, hi}, 64'd0);

        issue32(MD_MTHI, 32'h3, 32'd0);
        issue32(MD_MULT, 32'd2, 32'd3);
        step();
        step();
        chk("rst_mid_busy_before", {63'd0, busy}, 64'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_hi", {32'd0, hi}, 64'd0);
        chk("rst_mid_lo", {32'd0, lo}, 64'd0);
        issue32(MD_MTHI, 32'hA5, 32'd0);
        chk("post_rst_mthi", {32'd0, hi}, 64'hA5);
        repeat (6) step();
        chk("post_rst_lo", {32'd0, lo}, 64'd0);
        chk("post_rst_busy", {63'd0, busy}, 64'd0);

        issue32(MD_MULTU, 32'd2, 32'd3);
        wait_idle32(cyc);
        issue32(MD_MULTU, 32'd4, 32'd5);
        chk("b2b32_busy", {63'd0, busy}, 64'd1);
        wait_idle32(cyc);
        chk("b2b32_cycles", 64'(cyc), 64'd5);
        chk("b2b32_lo", {32'd0, lo}, 64'd20);

        issue16(MD_MULTU, 16'hFFFF, 16'hFFFF);
        chk("w16_busy", {63'd0, busy16}, 64'd1);
        wait_idle16(cyc);
        chk("w16_cycles", 64'(cyc), 64'd1);
        chk("w16_hi", {48'd0, hi16}, 64'hFFFE);
        chk("w16_lo", {48'd0, lo16}, 64'h0001);
        issue16(MD_MULTU, 16'd3, 16'd5);
        chk("w16_b2b_busy", {63'd0, busy16}, 64'd1);
        wait_idle16(cyc);
        chk("w16_b2b_lo", {48'd0, lo16}, 64'd15);
        chk("w16_b2b_hi", {48'd0, hi16}, 64'd0);
        alu_op16 = ALU_LUI; b16 = 16'h00AB;
        #1;
        chk("w16_lui", {48'd0, result16}, 64'hAB00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
